// File: rtl/nbody_seq.sv
// N-body step sequencer: issues all ordered body pairs, then a position sweep, per step.
// Optional completion interrupt is built when NBODY_SEQ_IRQ_EN is defined.

module nbody_seq_delay #(
  parameter int LAT = 1,
  parameter int W   = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [W-1:0] in_addr,
  output logic         out_valid,
  output logic [W-1:0] out_addr
);
  logic         v_reg [LAT];
  logic [W-1:0] a_reg [LAT];

  genvar gi;
  for (gi = 0; gi < LAT; gi++) begin : g_stage
    logic         v_in;
    logic [W-1:0] a_in;
    if (gi == 0) begin : g_head
      assign v_in = in_valid;
      assign a_in = in_addr;
    end else begin : g_link
      assign v_in = v_reg[gi-1];
      assign a_in = a_reg[gi-1];
    end
    // Address is zeroed alongside an empty slot so the tap needs no masking.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_reg[gi] <= 1'b0;
        a_reg[gi] <= '0;
      end else begin
        v_reg[gi] <= v_in && !flush;
        a_reg[gi] <= (v_in && !flush) ? a_in : '0;
      end
    end
  end

  assign out_valid = v_reg[LAT-1];
  assign out_addr  = a_reg[LAT-1];
endmodule

module nbody_seq #(
  parameter int BODIES     = 512,
  parameter int DATA_WIDTH = 64,
  parameter int ACCEL_LAT  = 99,
  parameter int ADD_LAT    = 20,
  localparam int BW        = $clog2(BODIES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  chipselect,
  input  logic                  read,
  input  logic                  write,
  input  logic [2:0]            addr,
  input  logic [DATA_WIDTH-1:0] writedata,
  output logic [DATA_WIDTH-1:0] readdata,
  output logic                  pair_valid,
  output logic [BW-1:0]         pair_i,
  output logic [BW-1:0]         pair_j,
  output logic                  acc_first,
  output logic                  acc_last,
  output logic                  vel_wr_en,
  output logic [BW-1:0]         vel_wr_addr,
  output logic                  pos_rd_en,
  output logic [BW-1:0]         pos_rd_addr,
  output logic                  pos_wr_en,
  output logic [BW-1:0]         pos_wr_addr,
  output logic                  irq
);
  typedef enum logic [2:0] {IDLE, PAIRS, DRAIN_A, POS, DRAIN_P} state_t;

  state_t                state_reg, state_next;
  logic [DATA_WIDTH-1:0] n_bodies_reg, steps_reg, steps_done_reg, readdata_reg, rd_data;
  logic                  done_reg, done_next, err_reg, err_next;
  logic [BW-1:0]         i_reg, j_reg, p_reg;
  logic [BW-1:0]         n_m1, j_first, j_last, j_step;
  logic                  bus_wr, bus_rd, ctrl_wr, start, abort, busy, flush;
  logic                  cfg_ok, start_ok, start_bad, pair_last, final_pair;
  logic                  vel_done, step_end, more_steps, status_rd;

  assign bus_wr    = chipselect && write;
  assign bus_rd    = chipselect && read;
  assign ctrl_wr   = bus_wr && (addr == 3'd0);
  assign abort     = ctrl_wr && writedata[1];
  assign start     = ctrl_wr && writedata[0] && !writedata[1];
  assign busy      = (state_reg != IDLE);
  assign flush     = abort && busy;
  assign status_rd = bus_rd && (addr == 3'd3);

  assign cfg_ok    = (n_bodies_reg >= DATA_WIDTH'(2)) && (n_bodies_reg <= DATA_WIDTH'(BODIES))
                     && (steps_reg != '0);
  assign start_ok  = start && !busy && cfg_ok;
  assign start_bad = start && !busy && !cfg_ok;

  // Low bits suffice once cfg_ok has bounded N to BODIES.
  assign n_m1       = n_bodies_reg[BW-1:0] - BW'(1);
  assign j_first    = (i_reg == BW'(0)) ? BW'(1) : BW'(0);
  assign j_last     = (i_reg == n_m1) ? n_m1 - BW'(1) : n_m1;
  assign j_step     = (j_reg + BW'(1) == i_reg) ? j_reg + BW'(2) : j_reg + BW'(1);
  assign pair_last  = (j_reg == j_last);
  assign final_pair = pair_last && (i_reg == n_m1);

  assign vel_done   = vel_wr_en && (vel_wr_addr == n_m1);
  assign step_end   = (state_reg == DRAIN_P) && pos_wr_en && (pos_wr_addr == n_m1) && !flush;
  assign more_steps = (steps_done_reg + DATA_WIDTH'(1)) < steps_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_ok) state_next = PAIRS;
      PAIRS:   if (final_pair) state_next = DRAIN_A;
      DRAIN_A: if (vel_done) state_next = POS;
      POS:     if (p_reg == n_m1) state_next = DRAIN_P;
      DRAIN_P: if (step_end) state_next = more_steps ? PAIRS : IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  always_comb begin
    pair_valid  = 1'b0;
    pair_i      = '0;
    pair_j      = '0;
    acc_first   = 1'b0;
    acc_last    = 1'b0;
    pos_rd_en   = 1'b0;
    pos_rd_addr = '0;
    case (state_reg)
      PAIRS: begin
        pair_valid = 1'b1;
        pair_i     = i_reg;
        pair_j     = j_reg;
        acc_first  = (j_reg == j_first);
        acc_last   = pair_last;
      end
      POS: begin
        pos_rd_en   = 1'b1;
        pos_rd_addr = p_reg;
      end
      default: ;
    endcase
  end

  always_comb begin
    done_next = done_reg;
    err_next  = err_reg;
    if (status_rd) done_next = 1'b0;
    if (start_ok) begin
      done_next = 1'b0;
      err_next  = 1'b0;
    end
    if (start_bad) err_next = 1'b1;
    if (step_end && !more_steps) done_next = 1'b1;
  end

  always_comb begin
    rd_data = '1;
    case (addr)
      3'd1:    rd_data = n_bodies_reg;
      3'd2:    rd_data = steps_reg;
      3'd3:    rd_data = {{(DATA_WIDTH-3){1'b0}}, err_reg, done_reg, busy};
      3'd4:    rd_data = steps_done_reg;
      default: rd_data = '1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_bodies_reg   <= '0;
      steps_reg      <= '0;
      steps_done_reg <= '0;
      readdata_reg   <= '0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
      i_reg          <= '0;
      j_reg          <= '0;
      p_reg          <= '0;
    end else begin
      if (bus_wr && !busy && addr == 3'd1) n_bodies_reg <= writedata;
      if (bus_wr && !busy && addr == 3'd2) steps_reg    <= writedata;
      if (bus_rd) readdata_reg <= rd_data;
      done_reg <= done_next;
      err_reg  <= err_next;
      if (start_ok)      steps_done_reg <= '0;
      else if (step_end) steps_done_reg <= steps_done_reg + DATA_WIDTH'(1);
      // Each new step restarts the pair walk at (0,1).
      if (state_next == PAIRS && state_reg != PAIRS) begin
        i_reg <= '0;
        j_reg <= BW'(1);
      end else if (state_reg == PAIRS) begin
        if (pair_last) begin
          i_reg <= i_reg + BW'(1);
          j_reg <= '0;
        end else begin
          j_reg <= j_step;
        end
      end
      p_reg <= (state_reg == POS) ? p_reg + BW'(1) : '0;
    end
  end

  assign readdata = readdata_reg;

  nbody_seq_delay #(.LAT(ACCEL_LAT), .W(BW)) u_vel_dly (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (pair_valid && acc_last),
    .in_addr   (pair_i),
    .out_valid (vel_wr_en),
    .out_addr  (vel_wr_addr)
  );

  nbody_seq_delay #(.LAT(ADD_LAT), .W(BW)) u_pos_dly (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (pos_rd_en),
    .in_addr   (pos_rd_addr),
    .out_valid (pos_wr_en),
    .out_addr  (pos_wr_addr)
  );

`ifdef NBODY_SEQ_IRQ_EN
  logic irq_en_reg, irq_en_next, irq_reg;
  assign irq_en_next = ctrl_wr ? writedata[2] : irq_en_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_en_reg <= 1'b0;
      irq_reg    <= 1'b0;
    end else begin
      irq_en_reg <= irq_en_next;
      irq_reg    <= done_next && irq_en_next;
    end
  end
  assign irq = irq_reg;
`else
  assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_nbody_seq.sv
// Self-checking bench for nbody_seq: event monitor plus a timeline model of each run.
module tb_nbody_seq;
  localparam int BODIES = 16;
  localparam int DW     = 32;
  localparam int AL     = 9;
  localparam int ADDL   = 4;
  localparam int BW     = $clog2(BODIES);
`ifdef NBODY_SEQ_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  typedef logic [63:0] q64_t[$];

  logic          clk = 1'b0, rst = 1'b1;
  logic          chipselect = 1'b0, read = 1'b0, write = 1'b0;
  logic [2:0]    addr = 3'd0;
  logic [DW-1:0] writedata = '0;
  logic [DW-1:0] readdata;
  logic          pair_valid, acc_first, acc_last, vel_wr_en, pos_rd_en, pos_wr_en, irq;
  logic [BW-1:0] pair_i, pair_j, vel_wr_addr, pos_rd_addr, pos_wr_addr;

  nbody_seq #(.BODIES(BODIES), .DATA_WIDTH(DW), .ACCEL_LAT(AL), .ADD_LAT(ADDL)) dut (
    .clk(clk), .rst(rst), .chipselect(chipselect), .read(read), .write(write),
    .addr(addr), .writedata(writedata), .readdata(readdata),
    .pair_valid(pair_valid), .pair_i(pair_i), .pair_j(pair_j),
    .acc_first(acc_first), .acc_last(acc_last),
    .vel_wr_en(vel_wr_en), .vel_wr_addr(vel_wr_addr),
    .pos_rd_en(pos_rd_en), .pos_rd_addr(pos_rd_addr),
    .pos_wr_en(pos_wr_en), .pos_wr_addr(pos_wr_addr), .irq(irq)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   checks = 0, errors = 0;
  int   zv = 0, irq_hi = 0;
  int   last_wr_cyc = 0;
  q64_t pq, vq, rq, wq, epq, evq, erq, ewq;

  always @(posedge clk) cyc <= cyc + 1;

  // Observed events, time-stamped with the cycle index seen at the falling edge.
  always @(negedge clk) begin
    if (pair_valid) pq.push_back({32'(cyc), 8'(pair_i), 8'(pair_j), 14'd0, acc_first, acc_last});
    else if (pair_i != 0 || pair_j != 0 || acc_first || acc_last) zv <= zv + 1;
    if (vel_wr_en) vq.push_back({32'(cyc), 32'(vel_wr_addr)});
    else if (vel_wr_addr != 0) zv <= zv + 1;
    if (pos_rd_en) rq.push_back({32'(cyc), 32'(pos_rd_addr)});
    else if (pos_rd_addr != 0) zv <= zv + 1;
    if (pos_wr_en) wq.push_back({32'(cyc), 32'(pos_wr_addr)});
    else if (pos_wr_addr != 0) zv <= zv + 1;
    if (irq) irq_hi <= irq_hi + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cmp_q(input string tag, input q64_t o, input q64_t e);
    bit bad = 0;
    check({tag, "_count"}, 64'(o.size()), 64'(e.size()));
    for (int k = 0; k < o.size() && k < e.size(); k++) begin
      if (!bad) begin
        if (o[k] !== e[k]) bad = 1;
        check(tag, o[k], e[k]);
      end
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    chipselect = 1; write = 1; addr = a; writedata = d; last_wr_cyc = cyc;
    @(negedge clk);
    chipselect = 0; write = 0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [DW-1:0] d);
    @(negedge clk);
    chipselect = 1; read = 1; addr = a;
    @(negedge clk);
    chipselect = 0; read = 0;
    d = readdata;
  endtask

  task automatic clear_q();
    pq.delete(); vq.delete(); rq.delete(); wq.delete();
    epq.delete(); evq.delete(); erq.delete(); ewq.delete();
  endtask

  // Expected timeline: ordered pairs back to back, velocity writes ACCEL_LAT after each
  // row ends, then a position sweep whose writes trail the reads by ADD_LAT.
  task automatic build(input int n, input int steps, input int s, output int e);
    int t, k, c, v;
    t = s + 1;
    for (int st = 0; st < steps; st++) begin
      k = 0;
      for (int i = 0; i < n; i++) begin
        c = 0;
        for (int j = 0; j < n; j++) begin
          if (i != j) begin
            epq.push_back({32'(t + k), 8'(i), 8'(j), 14'd0, c == 0, c == n - 2});
            if (c == n - 2) evq.push_back({32'(t + k + AL), 32'(i)});
            c++;
            k++;
          end
        end
      end
      v = t + k - 1 + AL;
      for (int a = 0; a < n; a++) begin
        erq.push_back({32'(v + 1 + a), 32'(a)});
        ewq.push_back({32'(v + 1 + a + ADDL), 32'(a)});
      end
      t = v + n + ADDL + 1;
    end
    e = t - 1;
  endtask

  task automatic run(input int n, input int steps, input logic [DW-1:0] ctrl);
    int s, e;
    logic [DW-1:0] d;
    clear_q();
    bus_write(3'd1, DW'(n));
    bus_write(3'd2, DW'(steps));
    bus_write(3'd0, ctrl);
    s = last_wr_cyc;
    bus_write(3'd1, DW'(99));
    bus_write(3'd2, DW'(0));
    build(n, steps, s, e);
    while (cyc < e + 2) @(negedge clk);
    cmp_q("pairs", pq, epq);
    cmp_q("vel_wr", vq, evq);
    cmp_q("pos_rd", rq, erq);
    cmp_q("pos_wr", wq, ewq);
    check("irq_level", 64'(irq), 64'(IRQ_ON && ctrl[2]));
    bus_read(3'd3, d); check("status_done", 64'(d), 64'h2);
    bus_read(3'd3, d); check("status_cleared", 64'(d), 64'h0);
    check("irq_after_read", 64'(irq), 64'h0);
    bus_read(3'd4, d); check("steps_done", 64'(d), 64'(steps));
    bus_read(3'd1, d); check("n_bodies_kept", 64'(d), 64'(n));
    bus_read(3'd2, d); check("steps_kept", 64'(d), 64'(steps));
    $display("run n=%0d steps=%0d pairs=%0d pos_wr=%0d", n, steps, pq.size(), wq.size());
  endtask

  task automatic err_run(input int n, input int steps);
    logic [DW-1:0] d;
    clear_q();
    bus_write(3'd1, DW'(n));
    bus_write(3'd2, DW'(steps));
    bus_write(3'd0, DW'(1));
    repeat (20) @(negedge clk);
    check("err_no_pairs", 64'(pq.size()), 64'd0);
    check("err_no_pos", 64'(rq.size()), 64'd0);
    bus_read(3'd3, d); check("err_status", 64'(d), 64'h4);
    $display("bad start n=%0d steps=%0d status=%0h", n, steps, d);
  endtask

  initial begin
    logic [DW-1:0] d;
    int s, e, a, target, late;
    q64_t keep;

    repeat (3) @(negedge clk);
    check("rst_readdata", 64'(readdata), 64'h0);
    check("rst_strobes", {59'd0, pair_valid, vel_wr_en, pos_rd_en, pos_wr_en, irq}, 64'h0);
    rst = 1'b0;
    bus_read(3'd1, d); check("rst_n_bodies", 64'(d), 64'h0);
    bus_read(3'd2, d); check("rst_steps", 64'(d), 64'h0);
    bus_read(3'd3, d); check("rst_status", 64'(d), 64'h0);
    bus_read(3'd6, d); check("unmapped_read", 64'(d), 64'hffff_ffff);

    run(3, 1, DW'(1));
    run(4, 3, DW'(1));

    err_run(1, 1);
    err_run(2, 0);
    err_run(BODIES + 1, 1);

    // Abort five cycles after the pair phase of an 8-body step ends.
    clear_q();
    bus_write(3'd1, DW'(8));
    bus_write(3'd2, DW'(1));
    bus_write(3'd0, DW'(1));
    s = last_wr_cyc;
    build(8, 1, s, e);
    target = s + 1 + 56 + 5;
    while (cyc < target - 1) @(negedge clk);
    bus_write(3'd0, DW'(3));
    a = last_wr_cyc;
    repeat (40) @(negedge clk);
    keep.delete();
    foreach (evq[k]) if (int'(evq[k][63:32]) <= a) keep.push_back(evq[k]);
    erq.delete();
    ewq.delete();
    cmp_q("abort_pairs", pq, epq);
    cmp_q("abort_vel", vq, keep);
    cmp_q("abort_pos_rd", rq, erq);
    cmp_q("abort_pos_wr", wq, ewq);
    bus_read(3'd3, d); check("abort_status", 64'(d), 64'h0);
    bus_read(3'd4, d); check("abort_steps_done", 64'(d), 64'h0);
    $display("abort at cycle %0d vel_wr=%0d status=%0h", a, vq.size(), d);

    run(BODIES, 1, DW'(1));
    check("last_pair", pq.size() > 0 ? pq[pq.size()-1][31:16] : 64'hdead,
          {48'd0, 8'(BODIES - 1), 8'(BODIES - 2)});

    for (int r = 0; r < 3; r++) run($urandom_range(2, 6), $urandom_range(1, 3), DW'(1));

    run(2, 1, DW'(5));

    // Reset in the middle of a pair phase.
    clear_q();
    bus_write(3'd1, DW'(5));
    bus_write(3'd2, DW'(2));
    bus_write(3'd0, DW'(1));
    repeat (10) @(negedge clk);
    #1 rst = 1'b1;
    s = cyc;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    late = 0;
    foreach (pq[k]) if (int'(pq[k][63:32]) > s) late++;
    foreach (vq[k]) if (int'(vq[k][63:32]) > s) late++;
    foreach (rq[k]) if (int'(rq[k][63:32]) > s) late++;
    foreach (wq[k]) if (int'(wq[k][63:32]) > s) late++;
    check("rst_pairs_before", 64'(pq.size() > 0), 64'd1);
    check("rst_no_late_strobes", 64'(late), 64'd0);
    bus_read(3'd1, d); check("rst_mid_n_bodies", 64'(d), 64'h0);
    bus_read(3'd3, d); check("rst_mid_status", 64'(d), 64'h0);
    $display("mid-run reset at cycle %0d late strobes=%0d", s, late);

    check("idle_outputs_zero", 64'(zv), 64'd0);
    check("irq_seen", 64'(irq_hi != 0), 64'(IRQ_ON));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
